irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 130 +++++++++++++
 tb/tb_irq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: samples irq lines into mip, arbitrates MEI > MSI > MTI,
// holds a trap request until acknowledged and enforces a holdoff after MRET. Option: IRQ_SYNC_EN.
module irq_ctrl #(
   parameter int unsigned INT_HOLDOFF = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       irq_ext_i,
   input  logic       irq_tim_i,
   input  logic       irq_sw_i,
   input  logic [2:0] mie_i,
   input  logic       mstatus_mie_i,
   input  logic       int_ack_i,
   input  logic       mret_i,
   output logic [2:0] mip_o,
   output logic       int_req_o,
   output logic [4:0] int_code_o,
   output logic       wfi_wake_o
);

   localparam logic [4:0] M_EXT_INT = 5'd11;
   localparam logic [4:0] M_SW_INT  = 5'd3;
   localparam logic [4:0] M_TIM_INT = 5'd7;

   typedef enum logic [1:0] {IDLE, REQ, IN_TRAP, HOLDOFF} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] code_q, code_d;
   logic       int_req_q;
   logic [2:0] mip_q;
   logic [2:0] irq_raw;
   logic [2:0] pend_en;
   logic       latched_live;
   logic [4:0] prio_code;

   assign irq_raw = {irq_ext_i, irq_tim_i, irq_sw_i};

`ifdef IRQ_SYNC_EN
   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         mip_q  <= '0;
      end else begin
         sync_q <= irq_raw;
         mip_q  <= sync_q;
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mip_q <= '0;
      else          mip_q <= irq_raw;
   end
`endif

   assign pend_en = mip_q & mie_i;

   always_comb begin
      if (pend_en[2])      prio_code = M_EXT_INT;
      else if (pend_en[0]) prio_code = M_SW_INT;
      else                 prio_code = M_TIM_INT;
   end

   // Withdrawal looks only at the cause already latched, not at whatever is now highest.
   always_comb begin
      case (code_q)
         M_EXT_INT: latched_live = pend_en[2];
         M_TIM_INT: latched_live = pend_en[1];
         M_SW_INT:  latched_live = pend_en[0];
         default:   latched_live = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         code_q    <= '0;
         int_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         int_req_q <= (state_d == REQ);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      case (state_q)
         IDLE: begin
            if (|pend_en && mstatus_mie_i) begin
               state_d = REQ;
               code_d  = prio_code;
            end
         end
         REQ: begin
            if (int_ack_i)                           state_d = IN_TRAP;
            else if (!latched_live || !mstatus_mie_i) state_d = IDLE;
         end
         IN_TRAP: begin
            if (mret_i) begin
               if (INT_HOLDOFF == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = HOLDOFF;
                  cnt_d   = 4'(INT_HOLDOFF);
               end
            end
         end
         HOLDOFF: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mip_o      = mip_q;
      int_req_o  = int_req_q;
      int_code_o = code_q;
      wfi_wake_o = |pend_en;
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; latency expectations follow IRQ_SYNC_EN.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       irq_ext_i = 1'b0, irq_tim_i = 1'b0, irq_sw_i = 1'b0;
   logic [2:0] mie_i = '0;
   logic       mstatus_mie_i = 1'b0;
   logic       int_ack_i = 1'b0;
   logic       mret_i = 1'b0;
   logic [2:0] mip_o;
   logic       int_req_o;
   logic [4:0] int_code_o;
   logic       wfi_wake_o;

   int n_checks = 0;
   int n_fail = 0;

   irq_ctrl #(.INT_HOLDOFF(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .irq_ext_i(irq_ext_i), .irq_tim_i(irq_tim_i), .irq_sw_i(irq_sw_i),
      .mie_i(mie_i), .mstatus_mie_i(mstatus_mie_i),
      .int_ack_i(int_ack_i), .mret_i(mret_i),
      .mip_o(mip_o), .int_req_o(int_req_o), .int_code_o(int_code_o), .wfi_wake_o(wfi_wake_o)
   );

   always #5 clk = ~clk;

   task automatic tick(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      irq_ext_i = 0; irq_tim_i = 0; irq_sw_i = 0;
      int_ack_i = 0; mret_i = 0; mie_i = 3'b111; mstatus_mie_i = 1;
      reset_n = 0;
      tick(2);
      reset_n = 1;
      tick(1);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (mip_o !== 3'b000) begin n_fail++; $display("FAIL rst_mip got=%b exp=000", mip_o); end
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", int_req_o); end
      n_checks++; if (int_code_o !== 5'd0) begin n_fail++; $display("FAIL rst_code got=%0d exp=0", int_code_o); end
      n_checks++; if (wfi_wake_o !== 1'b0) begin n_fail++; $display("FAIL rst_wfi got=%b exp=0", wfi_wake_o); end
   endtask

   task automatic test_latency();
      do_reset();
      irq_tim_i = 1;
      tick(LAT - 1);
      n_checks++; if (mip_o !== 3'b000) begin n_fail++; $display("FAIL lat_mip_early got=%b exp=000", mip_o); end
      tick(1);
      n_checks++; if (mip_o !== 3'b010) begin n_fail++; $display("FAIL lat_mip got=%b exp=010", mip_o); end
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL lat_req_early got=%b exp=0", int_req_o); end
      tick(1);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL lat_req got=%b exp=1", int_req_o); end
      n_checks++; if (int_code_o !== 5'd7) begin n_fail++; $display("FAIL lat_code got=%0d exp=7", int_code_o); end
      int_ack_i = 1;
      tick(1);
      int_ack_i = 0;
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL lat_ack_req got=%b exp=0", int_req_o); end
      tick(3);
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL lat_trap_ignore got=%b exp=0", int_req_o); end
      n_checks++; if (int_code_o !== 5'd7) begin n_fail++; $display("FAIL lat_code_retain got=%0d exp=7", int_code_o); end
   endtask

   task automatic test_priority();
      do_reset();
      irq_ext_i = 1; irq_tim_i = 1; irq_sw_i = 1;
      tick(LAT + 1);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL prio_req got=%b exp=1", int_req_o); end
      n_checks++; if (int_code_o !== 5'd11) begin n_fail++; $display("FAIL prio_code_ext got=%0d exp=11", int_code_o); end
      irq_ext_i = 0;
      tick(LAT + 1);
      n_checks++; if (int_code_o !== 5'd11) begin n_fail++; $display("FAIL prio_stable got=%0d exp=11", int_code_o); end
      // ext dropped, so the latched cause is gone: withdrawal expected before the ack
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL prio_withdraw got=%b exp=0", int_req_o); end
      tick(1);
      n_checks++; if (int_code_o !== 5'd3) begin n_fail++; $display("FAIL prio_code_sw got=%0d exp=3", int_code_o); end
      int_ack_i = 1;
      tick(1);
      int_ack_i = 0;
      mret_i = 1;
      tick(1);
      mret_i = 0;
      tick(2);
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL prio_holdoff got=%b exp=0", int_req_o); end
      tick(1);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL prio_rereq got=%b exp=1", int_req_o); end
      n_checks++; if (int_code_o !== 5'd3) begin n_fail++; $display("FAIL prio_next_code got=%0d exp=3", int_code_o); end
   endtask

   task automatic test_withdraw();
      do_reset();
      irq_tim_i = 1;
      tick(LAT + 1);
      irq_tim_i = 0;
      tick(LAT);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL wd_hold got=%b exp=1", int_req_o); end
      tick(1);
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL wd_drop got=%b exp=0", int_req_o); end
      n_checks++; if (int_code_o !== 5'd7) begin n_fail++; $display("FAIL wd_code got=%0d exp=7", int_code_o); end

      do_reset();
      irq_tim_i = 1;
      tick(LAT + 1);
      irq_tim_i = 0;
      tick(LAT);
      int_ack_i = 1;
      tick(1);
      int_ack_i = 0;
      irq_tim_i = 1;
      tick(LAT + 3);
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL wd_ack_wins got=%b exp=0", int_req_o); end
      mret_i = 1;
      tick(1);
      mret_i = 0;
      tick(3);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL wd_after_mret got=%b exp=1", int_req_o); end

      mstatus_mie_i = 0;
      tick(1);
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL wd_mstatus got=%b exp=0", int_req_o); end
   endtask

   task automatic test_ignored();
      do_reset();
      int_ack_i = 1;
      tick(2);
      int_ack_i = 0;
      irq_sw_i = 1;
      tick(LAT + 1);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL ign_ack_idle got=%b exp=1", int_req_o); end
      mret_i = 1;
      tick(1);
      mret_i = 0;
      tick(1);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL ign_mret_req got=%b exp=1", int_req_o); end
   endtask

   task automatic test_holdoff();
      do_reset();
      irq_sw_i = 1;
      tick(LAT + 1);
      int_ack_i = 1;
      tick(1);
      int_ack_i = 0;
      tick(2);
      mret_i = 1;
      tick(1);
      mret_i = 0;
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL ho_e1 got=%b exp=0", int_req_o); end
      tick(1);
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL ho_e2 got=%b exp=0", int_req_o); end
      tick(1);
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL ho_e3 got=%b exp=0", int_req_o); end
      tick(1);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL ho_e4 got=%b exp=1", int_req_o); end
      n_checks++; if (int_code_o !== 5'd3) begin n_fail++; $display("FAIL ho_code got=%0d exp=3", int_code_o); end
   endtask

   task automatic test_wfi_and_reset();
      do_reset();
      mstatus_mie_i = 0; mie_i = 3'b100; irq_ext_i = 1;
      tick(LAT);
      n_checks++; if (wfi_wake_o !== 1'b1) begin n_fail++; $display("FAIL wfi_wake got=%b exp=1", wfi_wake_o); end
      tick(3);
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL wfi_noreq got=%b exp=0", int_req_o); end
      mie_i = 3'b011;
      #1;
      n_checks++; if (wfi_wake_o !== 1'b0) begin n_fail++; $display("FAIL wfi_masked got=%b exp=0", wfi_wake_o); end
      mie_i = 3'b100; mstatus_mie_i = 1;
      tick(1);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL wfi_req got=%b exp=1", int_req_o); end
      #2;
      reset_n = 0;
      #1;
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL arst_req got=%b exp=0", int_req_o); end
      n_checks++; if (mip_o !== 3'b000) begin n_fail++; $display("FAIL arst_mip got=%b exp=000", mip_o); end
      n_checks++; if (int_code_o !== 5'd0) begin n_fail++; $display("FAIL arst_code got=%0d exp=0", int_code_o); end
      n_checks++; if (wfi_wake_o !== 1'b0) begin n_fail++; $display("FAIL arst_wfi got=%b exp=0", wfi_wake_o); end
      tick(1);
      reset_n = 1;
      tick(LAT);
      n_checks++; if (int_req_o !== 1'b0) begin n_fail++; $display("FAIL arst_restart_early got=%b exp=0", int_req_o); end
      tick(1);
      n_checks++; if (int_req_o !== 1'b1) begin n_fail++; $display("FAIL arst_restart got=%b exp=1", int_req_o); end
      n_checks++; if (int_code_o !== 5'd11) begin n_fail++; $display("FAIL arst_restart_code got=%0d exp=11", int_code_o); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_priority();
      test_withdraw();
      test_ignored();
      test_holdoff();
      test_wfi_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
